// File: rtl/conv3x3_engine.sv
// Sequential 3x3 convolution over a one-padded 4-bit feature map. Produces one
// unpadded output pixel per clock, with shift, ReLU and saturation to 4 bits.
module conv3x3_engine #(
  parameter int IN_SIZE  = 64,
  parameter int OUT_SIZE = IN_SIZE - 2,
  parameter int SHIFT    = 2,
  parameter int IN_BITS  = IN_SIZE * IN_SIZE * 4,
  parameter int OUT_BITS = OUT_SIZE * OUT_SIZE * 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_BITS-1:0]  input_matrix,
  input  logic [35:0]         weights,
  output logic [OUT_BITS-1:0] output_matrix,
  output logic                busy,
  output logic                done
);

  localparam int CW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int IIW = $clog2(IN_BITS);
  localparam int OIW = $clog2(OUT_BITS);
  localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      row_q, col_q;
  logic               last_pix;
  logic signed [12:0] acc;
  logic signed [12:0] scaled;
  logic [3:0]         pix_out;
  logic [OIW-1:0]     wr_base;

  // Unsigned pixel times signed tap, sign-extended to the accumulator width.
  function automatic logic signed [12:0] mac_term(input logic [3:0] px, input logic [3:0] w);
    logic signed [4:0] px_s;
    logic signed [3:0] w_s;
    logic signed [8:0] prod;
    px_s = signed'({1'b0, px});
    w_s  = signed'(w);
    prod = 9'(px_s) * 9'(w_s);
    return 13'(prod);
  endfunction

  // NOTE: combinational blocks use blocking '=' so the running sum is visible
  // to the next loop iteration within the same evaluation.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = acc + mac_term(
          input_matrix[IIW'(((int'(row_q) + i) * IN_SIZE + int'(col_q) + j) * 4) +: 4],
          weights[6'((i * 3 + j) * 4) +: 4]);
      end
    end
  end

  always_comb begin
    scaled = acc >>> SHIFT;
    if (scaled[12])
      pix_out = 4'd0;
    else if (scaled > 13'sd15)
      pix_out = 4'd15;
    else
      pix_out = scaled[3:0];
  end

  assign wr_base  = OIW'((int'(row_q) * OUT_SIZE + int'(col_q)) * 4);
  assign last_pix = (row_q == LAST) && (col_q == LAST);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_pix) state_d = DONE;
      DONE:    if (!start)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // NOTE: sequential state uses non-blocking '<='. The result map is a flop
  // bank rather than a RAM, so it is cleared by reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      output_matrix <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            row_q <= '0;
            col_q <= '0;
          end
        end
        RUN: begin
          output_matrix[wr_base +: 4] <= pix_out;
          if (last_pix) begin
            row_q <= '0;
            col_q <= '0;
          end else if (col_q == LAST) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine at IN_SIZE=6 with SHIFT=0 and SHIFT=2
// instances; expected pixel maps are queued per run and popped at done.
module tb_conv3x3_engine;

  localparam int IN_SIZE  = 6;
  localparam int OUT_SIZE = 4;
  localparam int IN_BITS  = IN_SIZE * IN_SIZE * 4;
  localparam int OUT_BITS = OUT_SIZE * OUT_SIZE * 4;
  localparam int NPIX     = OUT_SIZE * OUT_SIZE;

  logic                clk = 1'b0;
  logic                rst;
  logic                start0, start2;
  logic [IN_BITS-1:0]  in_m;
  logic [35:0]         w;
  logic [OUT_BITS-1:0] om0, om2;
  logic                busy0, busy2, done0, done2;

  bit                  sel;
  logic [OUT_BITS-1:0] om_s;
  logic                busy_s, done_s;

  logic [3:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv3x3_engine #(.IN_SIZE(IN_SIZE), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .input_matrix(in_m), .weights(w),
    .output_matrix(om0), .busy(busy0), .done(done0));

  conv3x3_engine #(.IN_SIZE(IN_SIZE), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .input_matrix(in_m), .weights(w),
    .output_matrix(om2), .busy(busy2), .done(done2));

  assign om_s   = sel ? om2   : om0;
  assign busy_s = sel ? busy2 : busy0;
  assign done_s = sel ? done2 : done0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [3:0] px, input logic [3:0] tap);
    for (int k = 0; k < IN_SIZE * IN_SIZE; k++) in_m[k*4 +: 4] = px;
    for (int k = 0; k < 9; k++) w[k*4 +: 4] = tap;
  endtask

  task automatic push_const(input logic [3:0] v);
    for (int k = 0; k < NPIX; k++) exp_q.push_back(v);
  endtask

  // Called just after a falling edge with the selected DUT in IDLE.
  task automatic run_check(input string tag, input bit drop);
    int cycles;
    int busy_hi;
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, busy_s, 1'b1);
    busy_hi = int'(busy_s);
    cycles  = 0;
    while (!done_s && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (!done_s) busy_hi += int'(busy_s);
    end
    check({tag, "_latency"}, cycles, NPIX);
    check({tag, "_busy_cycles"}, busy_hi, NPIX);
    check({tag, "_busy_at_done"}, busy_s, 1'b0);
    for (int k = 0; k < NPIX; k++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_pix%0d", tag, k), om_s[k*4 +: 4], e);
    end
    if (drop) begin
      @(negedge clk);
      if (sel) start2 = 1'b0; else start0 = 1'b0;
      @(posedge clk); #1;
      check({tag, "_done_fall"}, done_s, 1'b0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; sel = 1'b0;
    in_m = '0; w = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_om0", om0, '0);
    check("rst_om2", om2, '0);
    check("rst_busy", {busy0, busy2}, 2'b00);
    check("rst_done", {done0, done2}, 2'b00);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Ones everywhere: 9 taps of 1*1.
    fill(4'd1, 4'd1); push_const(4'd9);
    run_check("ones", 1'b1);

    // 15*7*9 = 945 saturates.
    fill(4'd15, 4'd7); push_const(4'd15);
    run_check("sat", 1'b1);

    // 5 * -1 * 9 = -45 clamps to zero.
    fill(4'd5, 4'hF); push_const(4'd0);
    run_check("relu", 1'b1);

    // Centre-tap identity kernel over random pixels.
    w = '0; w[4*4 +: 4] = 4'd1;
    for (int k = 0; k < IN_SIZE * IN_SIZE; k++) in_m[k*4 +: 4] = 4'($urandom_range(0, 15));
    for (int r = 0; r < OUT_SIZE; r++)
      for (int c = 0; c < OUT_SIZE; c++)
        exp_q.push_back(in_m[((r + 1) * IN_SIZE + c + 1) * 4 +: 4]);
    run_check("ident", 1'b1);

    // SHIFT=2: 4*1*9 = 36 >>> 2 = 9; hold start after done.
    sel = 1'b1;
    fill(4'd4, 4'd1); push_const(4'd9);
    run_check("shift2", 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", done2, 1'b1);
    check("hold_no_rerun", busy2, 1'b0);
    @(negedge clk); start2 = 1'b0;
    @(posedge clk); #1;
    check("drop_done", done2, 1'b0);
    @(negedge clk);
    fill(4'd8, 4'd1); push_const(4'd15);
    run_check("restart", 1'b1);

    // Reset five edges into a run clears everything at once.
    fill(4'd4, 4'd1);
    start2 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("midrst_om2", om2, '0);
    check("midrst_busy", busy2, 1'b0);
    check("midrst_done", done2, 1'b0);
    @(negedge clk); rst = 1'b0;
    push_const(4'd9);
    run_check("post_rst", 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
